chipkill_dec_sched: RTL and testbench
=====================================

CHIPKILL_DEC_SCHED -- requirements
Module: chipkill_dec_sched

Interface
REQ-001 SHALL have parameter TAG_W, default 4, request tag width returned unchanged with the response.
REQ-002 SHALL have parameter STARVE_MAX, default 8, maximum consecutive demand grants while a scrub request waits.
REQ-003 SHALL have parameter CNT_W, default 16, error-counter width.
REQ-004 SHALL have port clk, input, 1, single clock, rising edge; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports dmd_valid (in, 1), dmd_ready (out, 1), dmd_cw (in, 80), dmd_tag (in, TAG_W); these form the demand-read request.
REQ-007 SHALL have ports scb_valid (in, 1), scb_ready (out, 1), scb_cw (in, 80), scb_tag (in, TAG_W); these form the patrol-scrub request.
REQ-008 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_src (out, 1: 0=demand, 1=scrub), rsp_tag (out, TAG_W), rsp_data (out, 64), rsp_ce (out, 1, corrected), rsp_due (out, 1, uncorrectable), rsp_loc (out, 4, symbol index).
REQ-009 SHALL have ports ce_cnt and due_cnt (out, CNT_W) and last_loc (out, 4), present only under the configuration macro.

Function
REQ-010 SHALL share one 80-bit chipkill decoder (10 x 8-bit symbols, 64 data bits in [63:0]) between the two requesters.
REQ-011 SHALL transfer a request on a cycle where valid and ready are both high; a requester's valid, codeword and tag SHALL be held stable until it is accepted.
REQ-012 SHALL arbitrate by demand priority: the demand request wins unless scb_valid has seen STARVE_MAX consecutive demand grants, in which case scrub wins once and the starvation count clears.
REQ-013 SHALL clear the starvation count on any scrub grant, and on any cycle where scb_valid is low.
REQ-014 SHALL assert at most one of dmd_ready and scb_ready per cycle, and SHALL assert neither while stage 1 is full and cannot advance.
REQ-015 SHALL use a two-stage pipeline: stage 1 registers the codeword, tag and source; the decoder evaluates combinationally on stage 1; stage 2 registers the response.
REQ-016 SHALL give a latency of 2 cycles from the accept edge to rsp_valid when there is no backpressure, at a throughput of 1 per cycle.
REQ-017 SHALL hold all rsp_* outputs stable while rsp_valid=1 and rsp_ready=0; stage 1 SHALL advance only if stage 2 is empty or draining that cycle.
REQ-018 SHALL classify each response as follows: decoder fail flag set -> rsp_due=1, rsp_ce=0; otherwise a location other than 4'hF -> rsp_ce=1; 4'hF -> no error.
REQ-019 SHALL drive rsp_data as the decoder data output on every response, and SHALL set rsp_loc to 4'hF when there is no error.
REQ-020 SHALL return responses in acceptance order, with no reordering between sources.

Reset
REQ-021 SHALL, while rst_n is low, clear both pipeline valids, the starvation count, rsp_valid, dmd_ready, scb_ready, ce_cnt and due_cnt, and set last_loc=4'hF.
REQ-022 SHALL discard requests held in the pipeline when reset asserts mid-operation; they SHALL NOT be replayed.

Configuration
REQ-023 SHALL build the error log only when CHIPKILL_ERR_LOG_EN is defined: ce_cnt and due_cnt increment on each delivered (rsp_valid & rsp_ready) CE or DUE and saturate at all-ones; last_loc captures rsp_loc of the latest CE.
REQ-024 SHALL omit ce_cnt, due_cnt, last_loc and their logic when CHIPKILL_ERR_LOG_EN is undefined, leaving the response path unchanged.

Structure
REQ-025 SHALL place the constants CW_W=80, DATA_W=64, SYM_W=8, NSYM=10 and LOC_NONE=4'hF, plus the src_e enum {SRC_DMD, SRC_SCB}, in package chipkill_pkg.
REQ-026 SHALL instantiate the existing AMDCHIPKILL_DECODER as the only sub-module; arbitration and pipeline logic SHALL stay in chipkill_dec_sched.

Verification
REQ-027 SHALL cover: a demand request with codeword all zeros, tag 3 -> after 2 cycles rsp_src=0, tag 3, data 0, ce=0, due=0, loc=F.
REQ-028 SHALL cover: a scrub request with symbol 9 = 8'hA3 and the rest zero -> rsp_src=1, ce=1, loc=9, data 0, ce_cnt=1 with the macro defined.
REQ-029 SHALL cover: both valid continuously for 20 cycles -> scrub granted on cycle 9 and cycle 18, demand on all other cycles.
REQ-030 SHALL cover: rsp_ready held low for 5 cycles with 3 requests offered -> 2 accepted, outputs stable, no loss, in-order drain after release.
REQ-031 SHALL cover: two symbols corrupted -> due=1, due_cnt increments, and the counter holds at all-ones when preloaded to its maximum.
REQ-032 SHALL cover: rst_n pulsed low with two requests in flight -> rsp_valid stays 0 after reset and no stale response appears.

Source files
------------

// File: rtl/chipkill_pkg.sv
// Shared constants, source enum and GF(2^8) helpers for the chipkill scheduler.
// Field polynomial x^8+x^4+x^3+x^2+1, generator alpha = 2.
package chipkill_pkg;

  localparam int CW_W   = 80;
  localparam int DATA_W = 64;
  localparam int SYM_W  = 8;
  localparam int NSYM   = 10;

  localparam logic [3:0] LOC_NONE = 4'hF;
  localparam logic [7:0] GF_POLY  = 8'h1D;

  typedef enum logic {
    SRC_DMD = 1'b0,
    SRC_SCB = 1'b1
  } src_e;

  function automatic logic [7:0] gf_xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/chipkill_dec_sched_decoder.sv
// AMDCHIPKILL_DECODER: single-symbol-correct chipkill decode, 8 data + 2 check
// symbols, syndromes S0 = sum(sym), S1 = sum(alpha^i * sym).
module AMDCHIPKILL_DECODER
  import chipkill_pkg::*;
(
  input  logic [CW_W-1:0]   i_cw,
  output logic [DATA_W-1:0] o_data,
  output logic [3:0]        o_loc,
  output logic              o_fail
);

  logic [SYM_W-1:0] w_s0;
  logic [SYM_W-1:0] w_s1;
  logic [NSYM-1:0]  w_hit;

  always_comb begin
    logic [SYM_W-1:0] a;
    logic [SYM_W-1:0] sym;
    w_s0 = '0;
    w_s1 = '0;
    a    = 8'h01;
    for (int i = 0; i < NSYM; i++) begin
      sym  = i_cw[i*SYM_W +: SYM_W];
      w_s0 = w_s0 ^ sym;
      w_s1 = w_s1 ^ gf_mul(a, sym);
      a    = gf_xtime(a);
    end
  end

  // A single error at symbol j gives S1 == alpha^j * S0.
  always_comb begin
    logic [SYM_W-1:0] b;
    w_hit = '0;
    b     = 8'h01;
    for (int i = 0; i < NSYM; i++) begin
      w_hit[i] = (w_s0 != '0) && (gf_mul(b, w_s0) == w_s1);
      b        = gf_xtime(b);
    end
  end

  always_comb begin
    o_data = i_cw[DATA_W-1:0];
    o_loc  = LOC_NONE;
    o_fail = 1'b0;
    if (w_s0 != '0 || w_s1 != '0) begin
      if (w_hit == '0) begin
        o_fail = 1'b1;
      end else begin
        for (int i = 0; i < NSYM; i++) begin
          if (w_hit[i]) o_loc = 4'(i);
        end
        for (int i = 0; i < DATA_W / SYM_W; i++) begin
          if (w_hit[i])
            o_data[i*SYM_W +: SYM_W] =
              i_cw[i*SYM_W +: SYM_W] ^ w_s0;
        end
      end
    end
  end

endmodule

// File: rtl/chipkill_dec_sched.sv
// Demand/scrub arbiter feeding a shared chipkill decoder, 2-stage pipeline.
// Define CHIPKILL_ERR_LOG_EN to add ce_cnt/due_cnt/last_loc error logging.
module chipkill_dec_sched
  import chipkill_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmd_valid,
  output logic              dmd_ready,
  input  logic [CW_W-1:0]   dmd_cw,
  input  logic [TAG_W-1:0]  dmd_tag,
  input  logic              scb_valid,
  output logic              scb_ready,
  input  logic [CW_W-1:0]   scb_cw,
  input  logic [TAG_W-1:0]  scb_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_src,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ce,
  output logic              rsp_due,
  output logic [3:0]        rsp_loc
`ifdef CHIPKILL_ERR_LOG_EN
  ,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  due_cnt,
  output logic [3:0]        last_loc
`endif
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM =
    SC_W'(STARVE_MAX);

  logic [SC_W-1:0]   r_starve;
  logic              r_s1_vld;
  logic [CW_W-1:0]   r_s1_cw;
  logic [TAG_W-1:0]  r_s1_tag;
  src_e              r_s1_src;
  logic              r_s2_vld;
  src_e              r_s2_src;
  logic [TAG_W-1:0]  r_s2_tag;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_ce;
  logic              r_s2_due;
  logic [3:0]        r_s2_loc;

  logic              w_s2_free;
  logic              w_s1_free;
  logic              w_pick_scb;
  logic              w_dmd_acc;
  logic              w_scb_acc;
  logic [DATA_W-1:0] w_dec_data;
  logic [3:0]        w_dec_loc;
  logic              w_dec_fail;

  assign w_s2_free  = !r_s2_vld || rsp_ready;
  assign w_s1_free  = !r_s1_vld || w_s2_free;
  assign w_pick_scb = scb_valid &&
    (!dmd_valid || r_starve == STARVE_LIM);

  // Ready is gated by rst_n so neither side sees ready during reset.
  assign dmd_ready = rst_n && w_s1_free && !w_pick_scb;
  assign scb_ready = rst_n && w_s1_free && w_pick_scb;
  assign w_dmd_acc = dmd_valid && dmd_ready;
  assign w_scb_acc = scb_valid && scb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!scb_valid || w_scb_acc) begin
      r_starve <= '0;
    end else if (w_dmd_acc && r_starve != STARVE_LIM) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_cw  <= '0;
      r_s1_tag <= '0;
      r_s1_src <= SRC_DMD;
    end else if (w_s1_free) begin
      r_s1_vld <= w_dmd_acc || w_scb_acc;
      if (w_scb_acc) begin
        r_s1_cw  <= scb_cw;
        r_s1_tag <= scb_tag;
        r_s1_src <= SRC_SCB;
      end else if (w_dmd_acc) begin
        r_s1_cw  <= dmd_cw;
        r_s1_tag <= dmd_tag;
        r_s1_src <= SRC_DMD;
      end
    end
  end

  AMDCHIPKILL_DECODER u_dec (
    .i_cw   (r_s1_cw),
    .o_data (w_dec_data),
    .o_loc  (w_dec_loc),
    .o_fail (w_dec_fail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_src  <= SRC_DMD;
      r_s2_tag  <= '0;
      r_s2_data <= '0;
      r_s2_ce   <= 1'b0;
      r_s2_due  <= 1'b0;
      r_s2_loc  <= LOC_NONE;
    end else if (w_s2_free) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_src  <= r_s1_src;
        r_s2_tag  <= r_s1_tag;
        r_s2_data <= w_dec_data;
        r_s2_due  <= w_dec_fail;
        r_s2_ce   <= !w_dec_fail &&
                     (w_dec_loc != LOC_NONE);
        r_s2_loc  <= w_dec_loc;
      end
    end
  end

  assign rsp_valid = r_s2_vld;
  assign rsp_src   = r_s2_src;
  assign rsp_tag   = r_s2_tag;
  assign rsp_data  = r_s2_data;
  assign rsp_ce    = r_s2_ce;
  assign rsp_due   = r_s2_due;
  assign rsp_loc   = r_s2_loc;

`ifdef CHIPKILL_ERR_LOG_EN
  logic w_deliver;
  assign w_deliver = r_s2_vld && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_cnt   <= '0;
      due_cnt  <= '0;
      last_loc <= LOC_NONE;
    end else if (w_deliver) begin
      if (r_s2_ce && ce_cnt != '1)
        ce_cnt <= ce_cnt + 1'b1;
      if (r_s2_due && due_cnt != '1)
        due_cnt <= due_cnt + 1'b1;
      if (r_s2_ce)
        last_loc <= r_s2_loc;
    end
  end
`endif

endmodule

// File: tb/tb_chipkill_dec_sched.sv
// Directed self-checking bench for chipkill_dec_sched.
// Error-log checks are active when CHIPKILL_ERR_LOG_EN is defined.
module tb_chipkill_dec_sched;
  import chipkill_pkg::*;

  localparam int TAG_W = 4;
  localparam int CNT_W = 2;

  logic              clk;
  logic              rst_n;
  logic              dmd_valid;
  logic              dmd_ready;
  logic [CW_W-1:0]   dmd_cw;
  logic [TAG_W-1:0]  dmd_tag;
  logic              scb_valid;
  logic              scb_ready;
  logic [CW_W-1:0]   scb_cw;
  logic [TAG_W-1:0]  scb_tag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_src;
  logic [TAG_W-1:0]  rsp_tag;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ce;
  logic              rsp_due;
  logic [3:0]        rsp_loc;
`ifdef CHIPKILL_ERR_LOG_EN
  logic [CNT_W-1:0]  ce_cnt;
  logic [CNT_W-1:0]  due_cnt;
  logic [3:0]        last_loc;
`endif

  int errors = 0;
  int checks = 0;

  chipkill_dec_sched #(
    .TAG_W(TAG_W), .STARVE_MAX(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dmd_valid(dmd_valid), .dmd_ready(dmd_ready),
    .dmd_cw(dmd_cw), .dmd_tag(dmd_tag),
    .scb_valid(scb_valid), .scb_ready(scb_ready),
    .scb_cw(scb_cw), .scb_tag(scb_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_src(rsp_src), .rsp_tag(rsp_tag),
    .rsp_data(rsp_data), .rsp_ce(rsp_ce),
    .rsp_due(rsp_due), .rsp_loc(rsp_loc)
`ifdef CHIPKILL_ERR_LOG_EN
    , .ce_cnt(ce_cnt), .due_cnt(due_cnt),
    .last_loc(last_loc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dmd_valid = 1'b0; dmd_cw = '0; dmd_tag = '0;
    scb_valid = 1'b0; scb_cw = '0; scb_tag = '0;
    rsp_ready = 1'b1;
    #3;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    end
    checks++;
    if (dmd_ready !== 1'b0 || scb_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b want 00", dmd_ready, scb_ready);
    end
`ifdef CHIPKILL_ERR_LOG_EN
    checks++;
    if (ce_cnt !== 0 || due_cnt !== 0 || last_loc !== 4'hF) begin
      errors++;
      $display("FAIL reset_log: got ce=%0d due=%0d loc=%h want 0 0 f",
               ce_cnt, due_cnt, last_loc);
    end
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_demand_clean();
    dmd_valid = 1'b1; dmd_cw = '0; dmd_tag = 4'd3;
    #1;
    checks++;
    if (dmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL dmd_ready: got %b want 1", dmd_ready);
    end
    next_cyc();
    dmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL dmd_early_rsp: got %b want 0", rsp_valid);
    end
    next_cyc();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 1'b0 || rsp_tag !== 4'd3 ||
        rsp_data !== 64'd0 || rsp_ce !== 1'b0 || rsp_due !== 1'b0 ||
        rsp_loc !== 4'hF) begin
      errors++;
      $display("FAIL dmd_clean_rsp: got v=%b src=%b tag=%0d data=%h ce=%b due=%b loc=%h want 1 0 3 0 0 0 f",
               rsp_valid, rsp_src, rsp_tag, rsp_data, rsp_ce, rsp_due, rsp_loc);
    end
    next_cyc();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL dmd_rsp_drop: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_scrub_ce();
    scb_valid = 1'b1; scb_cw = '0; scb_tag = 4'd5;
    scb_cw[79:72] = 8'hA3;
    #1;
    checks++;
    if (scb_ready !== 1'b1 || dmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL scb_ready: got scb=%b dmd=%b want 1 0", scb_ready, dmd_ready);
    end
    next_cyc();
    scb_valid = 1'b0;
    next_cyc();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 1'b1 || rsp_tag !== 4'd5 ||
        rsp_data !== 64'd0 || rsp_ce !== 1'b1 || rsp_due !== 1'b0 ||
        rsp_loc !== 4'd9) begin
      errors++;
      $display("FAIL scb_ce_rsp: got v=%b src=%b tag=%0d data=%h ce=%b due=%b loc=%h want 1 1 5 0 1 0 9",
               rsp_valid, rsp_src, rsp_tag, rsp_data, rsp_ce, rsp_due, rsp_loc);
    end
    next_cyc();
`ifdef CHIPKILL_ERR_LOG_EN
    checks++;
    if (ce_cnt !== 2'd1 || last_loc !== 4'd9) begin
      errors++;
      $display("FAIL scb_ce_log: got ce=%0d loc=%h want 1 9", ce_cnt, last_loc);
    end
`endif
  endtask

  task automatic test_data_ce();
    dmd_valid = 1'b1; dmd_cw = '0; dmd_tag = 4'd7;
    dmd_cw[23:16] = 8'h55;
    next_cyc();
    dmd_valid = 1'b0;
    next_cyc();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 4'd7 || rsp_data !== 64'd0 ||
        rsp_ce !== 1'b1 || rsp_due !== 1'b0 || rsp_loc !== 4'd2) begin
      errors++;
      $display("FAIL data_ce_rsp: got v=%b tag=%0d data=%h ce=%b due=%b loc=%h want 1 7 0 1 0 2",
               rsp_valid, rsp_tag, rsp_data, rsp_ce, rsp_due, rsp_loc);
    end
    next_cyc();
  endtask

  task automatic test_due_saturate();
    logic [DATA_W-1:0] exp_data;
    exp_data = 64'h0000_0011_0000_1100;
    dmd_cw = '0;
    dmd_cw[15:8]  = 8'h11;
    dmd_cw[39:32] = 8'h11;
    for (int c = 1; c <= 7; c++) begin
      dmd_valid = (c <= 4);
      dmd_tag   = 4'(7 + c);
      #1;
      if (c <= 4) begin
        checks++;
        if (dmd_ready !== 1'b1) begin
          errors++;
          $display("FAIL due_b2b_ready c%0d: got %b want 1", c, dmd_ready);
        end
      end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_due !== 1'b1 || rsp_ce !== 1'b0 ||
            rsp_tag !== 4'(5 + c) || rsp_data !== exp_data) begin
          errors++;
          $display("FAIL due_rsp c%0d: got v=%b due=%b ce=%b tag=%0d data=%h want 1 1 0 %0d %h",
                   c, rsp_valid, rsp_due, rsp_ce, rsp_tag, rsp_data, 5 + c, exp_data);
        end
      end
`ifdef CHIPKILL_ERR_LOG_EN
      if (c == 4) begin
        checks++;
        if (due_cnt !== 2'd1) begin
          errors++;
          $display("FAIL due_cnt_inc: got %0d want 1", due_cnt);
        end
      end
`endif
      next_cyc();
    end
`ifdef CHIPKILL_ERR_LOG_EN
    checks++;
    if (due_cnt !== 2'd3 || ce_cnt !== 2'd2) begin
      errors++;
      $display("FAIL due_cnt_sat: got due=%0d ce=%0d want 3 2", due_cnt, ce_cnt);
    end
`endif
  endtask

  task automatic test_starvation();
    logic exp_g [1:20];
    dmd_cw = '0; dmd_tag = 4'd1;
    scb_cw = '0; scb_tag = 4'd2;
    for (int c = 1; c <= 22; c++) begin
      dmd_valid = (c <= 20);
      scb_valid = (c <= 20);
      #1;
      if (c <= 20) begin
        exp_g[c] = (c == 9 || c == 18);
        checks++;
        if (scb_ready !== exp_g[c] || dmd_ready !== !exp_g[c]) begin
          errors++;
          $display("FAIL starve_grant c%0d: got scb=%b dmd=%b want scb=%b",
                   c, scb_ready, dmd_ready, exp_g[c]);
        end
      end
      if (c >= 3) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_src !== exp_g[c-2] ||
            rsp_tag !== (exp_g[c-2] ? 4'd2 : 4'd1)) begin
          errors++;
          $display("FAIL starve_order c%0d: got v=%b src=%b tag=%0d want src=%b",
                   c, rsp_valid, rsp_src, rsp_tag, exp_g[c-2]);
        end
      end
      next_cyc();
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL starve_tail: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [CW_W-1:0]  cws  [3];
    logic [TAG_W-1:0] tags [3];
    logic [3:0]       locs [3];
    int idx;
    int outn;
    cws[0] = 80'h01;       tags[0] = 4'd4; locs[0] = 4'd0;
    cws[1] = 80'h02 << 24; tags[1] = 4'd5; locs[1] = 4'd3;
    cws[2] = 80'h04 << 40; tags[2] = 4'd6; locs[2] = 4'd5;
    idx = 0;
    outn = 0;
    for (int c = 1; c <= 10; c++) begin
      rsp_ready = (c > 5);
      dmd_valid = (idx < 3);
      if (idx < 3) begin
        dmd_cw  = cws[idx];
        dmd_tag = tags[idx];
      end
      #1;
      if (c >= 3 && c <= 5) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd4 || rsp_loc !== 4'd0 ||
            rsp_ce !== 1'b1 || dmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold c%0d: got v=%b tag=%0d loc=%h ce=%b rdy=%b want 1 4 0 1 0",
                   c, rsp_valid, rsp_tag, rsp_loc, rsp_ce, dmd_ready);
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (outn >= 3 || rsp_tag !== tags[outn] ||
            rsp_loc !== locs[outn] || rsp_ce !== 1'b1 ||
            rsp_data !== 64'd0) begin
          errors++;
          $display("FAIL bp_drain #%0d: got tag=%0d loc=%h ce=%b data=%h",
                   outn, rsp_tag, rsp_loc, rsp_ce, rsp_data);
        end
        outn++;
      end
      if (dmd_valid && dmd_ready) idx++;
      if (c == 5) begin
        checks++;
        if (idx != 2) begin
          errors++;
          $display("FAIL bp_accepted: got %0d want 2", idx);
        end
      end
      next_cyc();
    end
    checks++;
    if (idx != 3 || outn != 3) begin
      errors++;
      $display("FAIL bp_total: got acc=%0d out=%0d want 3 3", idx, outn);
    end
`ifdef CHIPKILL_ERR_LOG_EN
    checks++;
    if (ce_cnt !== 2'd3 || last_loc !== 4'd5) begin
      errors++;
      $display("FAIL bp_log: got ce=%0d loc=%h want 3 5", ce_cnt, last_loc);
    end
`endif
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    dmd_valid = 1'b1; dmd_cw = '0; dmd_tag = 4'd1;
    next_cyc();
    dmd_tag = 4'd2;
    next_cyc();
    dmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || dmd_ready !== 1'b0 || scb_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b dr=%b sr=%b want 0 0 0",
               rsp_valid, dmd_ready, scb_ready);
    end
`ifdef CHIPKILL_ERR_LOG_EN
    checks++;
    if (ce_cnt !== 0 || due_cnt !== 0 || last_loc !== 4'hF) begin
      errors++;
      $display("FAIL mid_reset_log: got ce=%0d due=%0d loc=%h want 0 0 f",
               ce_cnt, due_cnt, last_loc);
    end
`endif
    next_cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_stale c%0d: got %b want 0", c, rsp_valid);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_demand_clean();
    test_scrub_ce();
    test_data_ce();
    test_due_saturate();
    test_starvation();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
